// File: rtl/reaction_game_fsm.sv
// reaction_game_fsm: blue/red/green/score reaction-time game controller
// feeding the VGA drawing FSM with reactScreen and currentScore.
module reaction_game_fsm #(
  parameter int          CYCLES_PER_MS = 50000,
  parameter int          MIN_DELAY_MS  = 1000,
  parameter logic [15:0] DELAY_MASK    = 16'h07FF
) (
  input  logic        clk,
  input  logic        iResetn,
  input  logic        iClick,
  output logic [1:0]  reactScreen,
  output logic [11:0] currentScore,
  output logic [11:0] oBest,
  output logic        oTooEarly
);

  localparam int PW =
    (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
  localparam logic [PW-1:0] PS_LAST =
    PW'(CYCLES_PER_MS - 1);
  localparam logic [15:0] MIN_D = 16'(MIN_DELAY_MS);
  localparam logic [11:0] SCORE_MAX = 12'hFFF;
  localparam logic [15:0] SEED = 16'hACE1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_GO    = 2'd2,
    S_SCORE = 2'd3
  } state_t;

  logic          sync1;
  logic          sync2;
  logic          prev;
  logic          click;
  logic [15:0]   lfsr;
  logic          fb;
  logic [PW-1:0] presc;
  logic          tick;
  state_t        state;
  logic [15:0]   delay;
  logic [11:0]   score;
  logic [11:0]   best;
  logic          early;
  logic          go_wait;
  logic          go_go;

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= iClick;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign click = sync2 & ~prev;

  // taps 16,14,13,11 of the Fibonacci form, shifting right
  assign fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {fb, lfsr[15:1]};
    end
  end

  assign tick = (presc == PS_LAST);

  assign go_wait = (state == S_IDLE) && click;
  assign go_go   = (state == S_WAIT) && !click
                && tick && (delay == 16'd1);

  // restart on WAIT/GO entry so each ms is measured from entry
  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      presc <= '0;
    end else if (go_wait || go_go || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      state <= S_IDLE;
      delay <= 16'd0;
      score <= 12'd0;
      best  <= SCORE_MAX;
      early <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (click) begin
            state <= S_WAIT;
            delay <= MIN_D + (lfsr & DELAY_MASK);
            early <= 1'b0;
          end
        end
        S_WAIT: begin
          if (click) begin
            state <= S_IDLE;
            early <= 1'b1;
          end else if (tick) begin
            delay <= delay - 16'd1;
            if (delay == 16'd1) begin
              state <= S_GO;
              score <= 12'd0;
            end
          end
        end
        S_GO: begin
          if (click) begin
            state <= S_SCORE;
            if (score < best) begin
              best <= score;
            end
          end else if (tick && (score != SCORE_MAX)) begin
            score <= score + 12'd1;
          end
        end
        S_SCORE: begin
          if (click) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign reactScreen  = state;
  assign currentScore = score;
  assign oBest        = best;
  assign oTooEarly    = early;

endmodule

// File: tb/tb_reaction_game_fsm.sv
// tb_reaction_game_fsm: randomized game rounds against a ms-level model;
// screen transitions are checked by a scoreboard monitor.
module tb_reaction_game_fsm;

  localparam int          CPM   = 4;
  localparam int          MIN_D = 2;
  localparam logic [15:0] MASK  = 16'h0003;
  localparam int          SMAX  = 4095;

  logic        clk = 1'b0;
  logic        iResetn;
  logic        iClick;
  logic [1:0]  reactScreen;
  logic [11:0] currentScore;
  logic [11:0] oBest;
  logic        oTooEarly;

  reaction_game_fsm #(
    .CYCLES_PER_MS(CPM),
    .MIN_DELAY_MS (MIN_D),
    .DELAY_MASK   (MASK)
  ) dut (
    .clk         (clk),
    .iResetn     (iResetn),
    .iClick      (iClick),
    .reactScreen (reactScreen),
    .currentScore(currentScore),
    .oBest       (oBest),
    .oTooEarly   (oTooEarly)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int scr;
    int score;
    int best;
    int early;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc;
  logic [15:0] lfsr_m;
  int          m_score;
  int          m_best;
  int          m_early;
  int          last_scr = 0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    int   taps [4] = '{16, 14, 13, 11};
    logic f = 1'b0;
    foreach (taps[i]) f ^= x[16 - taps[i]];
    return {f, x[15:1]};
  endfunction

  // edges since reset release, and the generator value after that many shifts
  always @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      cyc    <= 0;
      lfsr_m <= 16'hACE1;
    end else begin
      cyc    <= cyc + 1;
      lfsr_m <= lfsr_step(lfsr_m);
    end
  end

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  function automatic void push(int c, int s);
    exp_t x;
    x.cyc   = c;
    x.scr   = s;
    x.score = m_score;
    x.best  = m_best;
    x.early = m_early;
    sb.push_back(x);
  endfunction

  always @(negedge clk) begin
    exp_t x;
    if (!iResetn) begin
      last_scr = 0;
    end else if (int'(reactScreen) != last_scr) begin
      last_scr = int'(reactScreen);
      if (sb.size() == 0) begin
        chk("unexpected_transition_to", last_scr, -1);
      end else begin
        x = sb.pop_front();
        chk("transition_cycle", cyc, x.cyc);
        chk("reactScreen", last_scr, x.scr);
        chk("currentScore", int'(currentScore), x.score);
        chk("oBest", int'(oBest), x.best);
        chk("oTooEarly", int'(oTooEarly), x.early);
      end
    end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
      x = sb.pop_front();
      chk("missing_transition_to", last_scr, x.scr);
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // the press lands so that the screen changes at edge e
  task automatic press_at(input int e);
    wait_until(e - 3);
    iClick = 1'b1;
  endtask

  task automatic release_after(input int h);
    repeat (h) @(negedge clk);
    iClick = 1'b0;
  endtask

  task automatic to_idle();
    int e;
    e = cyc + 6;
    press_at(e);
    push(e, 0);
    release_after(1);
  endtask

  task automatic enter_wait(input int hold, input bit with_go,
                            output int e, output int g);
    logic [15:0] lf;
    e = cyc + 6;
    press_at(e);
    lf = lfsr_step(lfsr_step(lfsr_m));
    m_early = 0;
    push(e, 1);
    g = e + CPM * (MIN_D + int'(lf & MASK));
    if (with_go) begin
      m_score = 0;
      push(g, 2);
    end
    release_after(hold);
  endtask

  // whole ms elapsed in GO before the click edge, capped
  task automatic score_at(input int g, input int e);
    int s;
    press_at(e);
    s = (e - g - 1) / CPM;
    if (s > SMAX) s = SMAX;
    m_score = s;
    if (s < m_best) m_best = s;
    push(e, 3);
    release_after(1);
    to_idle();
  endtask

  task automatic early_click(input int e);
    press_at(e);
    m_early = 1;
    push(e, 0);
    release_after(1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int e, g, h;
    iResetn = 1'b0;
    iClick  = 1'b0;
    m_score = 0;
    m_best  = SMAX;
    m_early = 0;
    #12;
    chk("reset_reactScreen", int'(reactScreen), 0);
    chk("reset_currentScore", int'(currentScore), 0);
    chk("reset_oBest", int'(oBest), SMAX);
    chk("reset_oTooEarly", int'(oTooEarly), 0);
    iResetn = 1'b1;
    @(negedge clk);

    enter_wait(200, 1'b1, e, g);
    score_at(g, cyc + 6);

    enter_wait(1, 1'b1, e, g);
    score_at(g, g + 21);
    chk("best_after_score5", int'(oBest), 5);

    enter_wait(1, 1'b0, e, g);
    early_click(e + 3);
    wait_until(e + 4);
    chk("early_flag", int'(oTooEarly), 1);
    chk("early_score_held", int'(currentScore), 5);

    for (int i = 0; i < 6; i++) begin
      h = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) begin
        enter_wait(h, 1'b0, e, g);
        early_click(e + $urandom_range(3, g - e - 1));
      end else begin
        enter_wait(h, 1'b1, e, g);
        score_at(g, g + $urandom_range(25, 80));
      end
    end

    enter_wait(1, 1'b1, e, g);
    score_at(g, g + 37 + $urandom_range(0, 3));
    chk("best_kept_after_9", int'(oBest), 5);
    enter_wait(1, 1'b1, e, g);
    score_at(g, g + 9 + $urandom_range(0, 3));
    chk("best_after_2", int'(oBest), 2);
    enter_wait(1, 1'b0, e, g);
    early_click(g);
    wait_until(g + 1);
    chk("click_on_last_tick", int'(oTooEarly), 1);

    enter_wait(1, 1'b1, e, g);
    wait_until(g + CPM * 4095 - 1);
    chk("score_before_sat", int'(currentScore), 4094);
    wait_until(g + CPM * 4095);
    chk("score_sat", int'(currentScore), 4095);
    wait_until(g + CPM * 4096 + 8);
    chk("score_sat_hold", int'(currentScore), 4095);
    score_at(g, cyc + 6);
    chk("best_after_sat", int'(oBest), 2);

    enter_wait(1, 1'b1, e, g);
    wait_until(g + 13);
    chk("midgo_score", int'(currentScore), 3);
    chk("midgo_best", int'(oBest), 2);
    #1 iResetn = 1'b0;
    #1;
    chk("areset_reactScreen", int'(reactScreen), 0);
    chk("areset_currentScore", int'(currentScore), 0);
    chk("areset_oBest", int'(oBest), SMAX);
    chk("areset_oTooEarly", int'(oTooEarly), 0);
    m_score = 0;
    m_best  = SMAX;
    m_early = 0;
    @(negedge clk);
    @(negedge clk);
    #1 iResetn = 1'b1;
    @(negedge clk);

    enter_wait(1, 1'b1, e, g);
    score_at(g, g + $urandom_range(5, 40));
    enter_wait(1, 1'b1, e, g);
    score_at(g, g + 2);
    chk("best_zero", int'(oBest), 0);

    repeat (10) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reaction_game_fsm.md
# reaction_game_fsm

Game controller for the reaction-time benchmark. It sits directly upstream of the VGA drawing FSM and drives that FSM's `reactScreen` and `currentScore` inputs. It watches the mouse left-button level and runs the blue → red → green → score sequence. It times the random red delay and measures the reaction time in milliseconds.

## Interface
Parameters:
- `CYCLES_PER_MS`, 50000: clk cycles per millisecond tick (50 MHz clk).
- `MIN_DELAY_MS`, 1000: minimum red-screen duration in ms.
- `DELAY_MASK`, 16'h07FF: mask ANDed with the LFSR to form the random extra delay.

Ports:
- `clk`  in  1  system clock. One clock; every register is in this domain.
- `iResetn`  in  1  reset, asynchronous, active-low.
- `iClick`  in  1  raw mouse left-button level. May be asynchronous to `clk`.
- `reactScreen`  out  2  screen select: 0 blue/idle, 1 red/wait, 2 green/go, 3 score.
- `currentScore`  out  12  reaction time in ms.
- `oBest`  out  12  best (lowest) score since reset.
- `oTooEarly`  out  1  set when the last attempt was aborted by an early click.

## Operation
Click detection:
- `iClick` passes through a 2-flop synchronizer, then a previous-value register.
- `click` = sync2 & ~prev. It is a one-cycle pulse per button press.
- Holding the button produces exactly one pulse.

Free-running generators:
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
- The LFSR shifts every cycle. Its reset seed is 16'hACE1.
- Ms prescaler: counts 0..`CYCLES_PER_MS`-1. `tick` is asserted on the wrap.
- The prescaler is cleared on entry to WAIT and on entry to GO.

States (`reactScreen` = state encoding):
- IDLE (0) on `click`: go to WAIT.
  - Load `delay` = `MIN_DELAY_MS` + (lfsr & `DELAY_MASK`), 16-bit, using the LFSR value in that cycle.
  - Clear `oTooEarly`.
- WAIT (1) on `click`: go to IDLE and set `oTooEarly`. `currentScore` is unchanged.
- WAIT (1) otherwise, on `tick`: decrement `delay`.
  - When `tick` arrives with `delay` == 1, go to GO and clear `currentScore` to 0.
- GO (2) on `tick`: increment `currentScore`, saturating at 4095.
- GO (2) on `click`: go to SCORE and freeze `currentScore`.
  - If `currentScore` < `oBest`, load `oBest` with `currentScore`.
- SCORE (3) on `click`: go to IDLE. `currentScore` is held.
- Encodings are only 0–3; there are no illegal states.

## Timing
Reset values (asserted asynchronously):
- State = IDLE, so `reactScreen` = 0.
- `currentScore` = 0, `oBest` = 4095, `oTooEarly` = 0.
- LFSR = 16'hACE1. Prescaler, `delay` and synchronizer flops = 0.

Click latency:
- `iClick` high before rising edge k → synchronized at k+1 → state/outputs update at edge k+2.
- All outputs are registered.

Measurement:
- `currentScore` increments exactly once per `CYCLES_PER_MS` cycles in GO.
- The first increment comes `CYCLES_PER_MS` cycles after GO entry.
- Red duration = `delay` × `CYCLES_PER_MS` cycles ±1 from WAIT entry.

Simultaneous events:
- `click` and final `tick` in WAIT: the click wins, giving IDLE with `oTooEarly`=1.
- `click` and `tick` in GO: the click wins, and that tick's increment is discarded.
- Score equal to `oBest`: `oBest` is unchanged.
- Score 0 (click within first ms of GO) is legal and updates `oBest`.

Reset mid-operation:
- Asserting `iResetn` low in any state returns immediately to the reset values, including `oBest`.

## Test plan
Parameters for the bench: `CYCLES_PER_MS`=4, `MIN_DELAY_MS`=2, `DELAY_MASK`=16'h0003.

1. Reset then release → `reactScreen`=0, `currentScore`=0, `oBest`=4095, `oTooEarly`=0. A 200-cycle hold of `iClick`=1 then 0 → exactly one transition, to `reactScreen`=1, two edges after the synchronized rise.
2. Full round: enter WAIT, then compute `delay` from the LFSR model. Check `reactScreen`=2 after `delay`×4 (±1) cycles. Click 21 cycles after GO entry → `reactScreen`=3, `currentScore`=5, `oBest`=5.
3. Early click in WAIT after 3 cycles → `reactScreen`=0, `oTooEarly`=1, `currentScore` holds the prior value. The next click → WAIT with `oTooEarly`=0.
4. Second round scored 9 after a best of 5 → `oBest` stays 5. A round scored 2 → `oBest`=2. A click landing on the same cycle as the expiring tick (WAIT) → IDLE with `oTooEarly`=1.
5. Never click in GO for 4096×4+8 cycles → `currentScore` saturates at 4095 and holds. A click → SCORE with 4095, and `oBest` is unchanged.
6. Assert `iResetn` low asynchronously mid-GO with `currentScore`=3 and `oBest`=2 → all outputs return to reset values before the next clk edge.
